// File: rtl/tboom_rename_map_table_ckpt.sv
// Superscalar rename map table with a circular checkpoint stack for branch recovery.
// Optional macro TBOOM_RMT_X0_HARDWIRE_EN pins architectural x0 to physical register 0.
module tboom_rename_map_table_ckpt #(
    parameter int ARCH_REGS    = 32,
    parameter int PHYS_REGS    = 64,
    parameter int RENAME_WIDTH = 2,
    parameter int NUM_CKPT     = 8,
    localparam int AW = $clog2(ARCH_REGS),
    localparam int PW = $clog2(PHYS_REGS),
    localparam int CW = $clog2(NUM_CKPT),
    localparam int LW = (RENAME_WIDTH > 1) ? $clog2(RENAME_WIDTH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RENAME_WIDTH-1:0]    ren_valid,
    input  logic [RENAME_WIDTH*AW-1:0] arch_rs1,
    input  logic [RENAME_WIDTH*AW-1:0] arch_rs2,
    input  logic [RENAME_WIDTH*AW-1:0] arch_rd,
    input  logic [RENAME_WIDTH-1:0]    rd_we,
    input  logic [RENAME_WIDTH*PW-1:0] phys_rd_new,
    input  logic                       ckpt_req,
    input  logic [LW-1:0]              ckpt_lane,
    input  logic                       ckpt_release,
    input  logic                       restore,
    input  logic [CW-1:0]              restore_id,
    output logic [RENAME_WIDTH*PW-1:0] phys_rs1,
    output logic [RENAME_WIDTH*PW-1:0] phys_rs2,
    output logic [RENAME_WIDTH*PW-1:0] phys_stale,
    output logic [RENAME_WIDTH-1:0]    out_valid,
    output logic                       ckpt_ack,
    output logic [CW-1:0]              ckpt_id,
    output logic                       ckpt_full,
    output logic                       ckpt_empty
);

    logic [PW-1:0] map_q  [ARCH_REGS];
    logic [PW-1:0] map_d  [ARCH_REGS];
    logic [PW-1:0] ckpt_map_s [ARCH_REGS];
    logic [PW-1:0] slot_q [NUM_CKPT][ARCH_REGS];
    logic [CW-1:0] head_q, tail_q, off_s;
    logic [CW:0]   count_q;
    logic [RENAME_WIDTH-1:0]    we_s;
    logic [RENAME_WIDTH*PW-1:0] rs1_s, rs2_s, stale_s;
    logic restore_ok_s, take_s, rel_s;

    assign ckpt_full  = (count_q == (CW+1)'(NUM_CKPT));
    assign ckpt_empty = (count_q == {(CW+1){1'b0}});

    // A restore is honoured only for a slot inside the live window [head, tail).
    assign off_s        = restore_id - head_q;
    assign restore_ok_s = restore & ({1'b0, off_s} < count_q);
    assign take_s       = ckpt_req & ~restore_ok_s & ~ckpt_full;
    assign rel_s        = ckpt_release & ~restore_ok_s & ~ckpt_empty;

    // Lane write enables, same-group bypass lookups, next map and checkpoint image.
    always_comb begin
        for (int i = 0; i < RENAME_WIDTH; i++) begin
`ifdef TBOOM_RMT_X0_HARDWIRE_EN
            we_s[i] = ren_valid[i] & rd_we[i] & (arch_rd[i*AW +: AW] != {AW{1'b0}});
`else
            we_s[i] = ren_valid[i] & rd_we[i];
`endif
        end
        for (int j = 0; j < RENAME_WIDTH; j++) begin
            rs1_s[j*PW +: PW]   = map_q[arch_rs1[j*AW +: AW]];
            rs2_s[j*PW +: PW]   = map_q[arch_rs2[j*AW +: AW]];
            stale_s[j*PW +: PW] = map_q[arch_rd[j*AW +: AW]];
            // Later (younger) older-lanes override earlier ones.
            for (int i = 0; i < j; i++) begin
                rs1_s[j*PW +: PW] = (we_s[i] && arch_rd[i*AW +: AW] == arch_rs1[j*AW +: AW])
                                    ? phys_rd_new[i*PW +: PW] : rs1_s[j*PW +: PW];
                rs2_s[j*PW +: PW] = (we_s[i] && arch_rd[i*AW +: AW] == arch_rs2[j*AW +: AW])
                                    ? phys_rd_new[i*PW +: PW] : rs2_s[j*PW +: PW];
                stale_s[j*PW +: PW] = (we_s[i] && arch_rd[i*AW +: AW] == arch_rd[j*AW +: AW])
                                      ? phys_rd_new[i*PW +: PW] : stale_s[j*PW +: PW];
            end
        end
        map_d      = map_q;
        ckpt_map_s = map_q;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            map_d[arch_rd[i*AW +: AW]] = we_s[i] ? phys_rd_new[i*PW +: PW]
                                                 : map_d[arch_rd[i*AW +: AW]];
            ckpt_map_s[arch_rd[i*AW +: AW]] = (we_s[i] && (LW'(i) <= ckpt_lane))
                                              ? phys_rd_new[i*PW +: PW]
                                              : ckpt_map_s[arch_rd[i*AW +: AW]];
        end
    end

    // Map, checkpoint stack pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < ARCH_REGS; a++) begin
                map_q[a] <= PW'(a);
                for (int c = 0; c < NUM_CKPT; c++) begin
                    slot_q[c][a] <= PW'(a);
                end
            end
            head_q     <= {CW{1'b0}};
            tail_q     <= {CW{1'b0}};
            count_q    <= {(CW+1){1'b0}};
            phys_rs1   <= {(RENAME_WIDTH*PW){1'b0}};
            phys_rs2   <= {(RENAME_WIDTH*PW){1'b0}};
            phys_stale <= {(RENAME_WIDTH*PW){1'b0}};
            out_valid  <= {RENAME_WIDTH{1'b0}};
            ckpt_ack   <= 1'b0;
            ckpt_id    <= {CW{1'b0}};
        end else if (restore_ok_s) begin
            map_q     <= slot_q[restore_id];
            tail_q    <= restore_id + CW'(1'b1);
            count_q   <= {1'b0, off_s} + (CW+1)'(1'b1);
            out_valid <= {RENAME_WIDTH{1'b0}};
            ckpt_ack  <= 1'b0;
        end else begin
            map_q <= map_d;
            if (take_s) begin
                slot_q[tail_q] <= ckpt_map_s;
                tail_q         <= tail_q + CW'(1'b1);
                ckpt_id        <= tail_q;
            end else begin
                tail_q <= tail_q;
            end
            if (rel_s) begin
                head_q <= head_q + CW'(1'b1);
            end else begin
                head_q <= head_q;
            end
            count_q    <= count_q + (CW+1)'(take_s) - (CW+1)'(rel_s);
            phys_rs1   <= rs1_s;
            phys_rs2   <= rs2_s;
            phys_stale <= stale_s;
            out_valid  <= ren_valid;
            ckpt_ack   <= take_s;
        end
    end

endmodule

// File: tb/tb_tboom_rename_map_table_ckpt.sv
// Bench for tboom_rename_map_table_ckpt: directed scenarios plus randomized traffic
// checked against an array-based reference model of the map and checkpoint stack.
module tb_tboom_rename_map_table_ckpt;
    localparam int AW = 5, PW = 6, RW = 2, NC = 8, CW = 3;

    logic clk = 1'b0;
    logic rst;
    logic [RW-1:0]    ren_valid, rd_we, out_valid;
    logic [RW*AW-1:0] arch_rs1, arch_rs2, arch_rd;
    logic [RW*PW-1:0] phys_rd_new, phys_rs1, phys_rs2, phys_stale;
    logic ckpt_req, ckpt_release, restore, ckpt_ack, ckpt_full, ckpt_empty;
    logic [0:0]    ckpt_lane;
    logic [CW-1:0] restore_id, ckpt_id;

    int checks = 0, failures = 0;

    // reference model state
    int mmap[32];
    int slots[8][32];
    int m_head, m_tail, m_count;
    int e_rs1[RW], e_rs2[RW], e_st[RW];
    logic [RW-1:0] e_ov;
    logic e_ack;
    int e_id;

    tboom_rename_map_table_ckpt dut (
        .clk(clk), .rst(rst), .ren_valid(ren_valid), .arch_rs1(arch_rs1),
        .arch_rs2(arch_rs2), .arch_rd(arch_rd), .rd_we(rd_we), .phys_rd_new(phys_rd_new),
        .ckpt_req(ckpt_req), .ckpt_lane(ckpt_lane), .ckpt_release(ckpt_release),
        .restore(restore), .restore_id(restore_id), .phys_rs1(phys_rs1),
        .phys_rs2(phys_rs2), .phys_stale(phys_stale), .out_valid(out_valid),
        .ckpt_ack(ckpt_ack), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
        .ckpt_empty(ckpt_empty)
    );

    always #5 clk = ~clk;

    function automatic int rdl(int l);  return int'(arch_rd[l*AW +: AW]);      endfunction
    function automatic int pnew(int l); return int'(phys_rd_new[l*PW +: PW]);  endfunction

    function automatic bit lane_wr(int l);
        bit w;
        w = ren_valid[l] && rd_we[l];
`ifdef TBOOM_RMT_X0_HARDWIRE_EN
        if (rdl(l) == 0) w = 0;
`endif
        return w;
    endfunction

    // youngest older lane writing register a wins; otherwise the committed map
    function automatic int look(int j, int a);
        for (int i = j - 1; i >= 0; i--)
            if (lane_wr(i) && rdl(i) == a) return pnew(i);
        return mmap[a];
    endfunction

    task automatic model_step();
        int ck[32];
        int off;
        bit rok, take, rel;
        if (rst) begin
            for (int a = 0; a < 32; a++) begin
                mmap[a] = a;
                for (int c = 0; c < NC; c++) slots[c][a] = a;
            end
            m_head = 0; m_tail = 0; m_count = 0;
            e_ov = '0; e_ack = 0; e_id = 0;
            for (int j = 0; j < RW; j++) begin e_rs1[j] = 0; e_rs2[j] = 0; e_st[j] = 0; end
        end else begin
            off = (int'(restore_id) - m_head + NC) % NC;
            rok = restore && (off < m_count);
            if (rok) begin
                mmap = slots[restore_id];
                m_tail = (int'(restore_id) + 1) % NC;
                m_count = off + 1;
                e_ov = '0; e_ack = 0;
            end else begin
                for (int j = 0; j < RW; j++) begin
                    e_rs1[j] = look(j, int'(arch_rs1[j*AW +: AW]));
                    e_rs2[j] = look(j, int'(arch_rs2[j*AW +: AW]));
                    e_st[j]  = look(j, rdl(j));
                end
                e_ov = ren_valid;
                take = ckpt_req && (m_count != NC);
                rel  = ckpt_release && (m_count > 0);
                ck = mmap;
                for (int i = 0; i <= int'(ckpt_lane); i++) if (lane_wr(i)) ck[rdl(i)] = pnew(i);
                for (int i = 0; i < RW; i++) if (lane_wr(i)) mmap[rdl(i)] = pnew(i);
                if (take) begin
                    slots[m_tail] = ck;
                    e_id = m_tail;
                    m_tail = (m_tail + 1) % NC;
                end
                if (rel) m_head = (m_head + 1) % NC;
                m_count = m_count + int'(take) - int'(rel);
                e_ack = take;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; ren_valid = '0; rd_we = '0; arch_rs1 = '0; arch_rs2 = '0; arch_rd = '0;
        phys_rd_new = '0; ckpt_req = 0; ckpt_lane = '0; ckpt_release = 0;
        restore = 0; restore_id = '0;
    endtask

    task automatic lane(int l, bit v, int r1, int r2, int rd, bit we, int pn);
        ren_valid[l] = v; rd_we[l] = we;
        arch_rs1[l*AW +: AW] = AW'(r1); arch_rs2[l*AW +: AW] = AW'(r2);
        arch_rd[l*AW +: AW] = AW'(rd);  phys_rd_new[l*PW +: PW] = PW'(pn);
    endtask

    task automatic do_reset();
        idle(); rst = 1; cycle(); idle();
    endtask

    task automatic test_reset();
        idle();
        lane(0, 1, 3, 4, 9, 1, 17); lane(1, 1, 9, 2, 6, 1, 12); ckpt_req = 1;
        cycle();
        idle(); rst = 1; ckpt_req = 1; lane(0, 1, 1, 1, 1, 1, 1);
        cycle();
        idle();
        checks++; if ({out_valid, ckpt_ack, ckpt_id} !== '0) begin
            failures++; $display("FAIL reset_ctrl got ov=%b ack=%b id=%0d want 0", out_valid, ckpt_ack, ckpt_id); end
        checks++; if ({phys_rs1, phys_rs2, phys_stale} !== '0) begin
            failures++; $display("FAIL reset_phys got %h %h %h want 0", phys_rs1, phys_rs2, phys_stale); end
        checks++; if (ckpt_full !== 1'b0 || ckpt_empty !== 1'b1) begin
            failures++; $display("FAIL reset_flags got full=%b empty=%b want 0 1", ckpt_full, ckpt_empty); end
    endtask

    task automatic test_basic_lookup();
        do_reset();
        lane(0, 1, 5, 7, 3, 0, 0);
        cycle();
        checks++; if (phys_rs1[5:0] !== 6'd5 || phys_rs2[5:0] !== 6'd7 || phys_stale[5:0] !== 6'd3) begin
            failures++; $display("FAIL basic_lookup got %0d %0d %0d want 5 7 3", phys_rs1[5:0], phys_rs2[5:0], phys_stale[5:0]); end
        checks++; if (out_valid !== 2'b01) begin
            failures++; $display("FAIL basic_ov got %b want 01", out_valid); end
    endtask

    task automatic test_bypass();
        do_reset();
        lane(0, 1, 0, 0, 4, 1, 40); lane(1, 1, 4, 0, 4, 1, 41);
        cycle();
        checks++; if (phys_rs1[11:6] !== 6'd40 || phys_stale[11:6] !== 6'd40) begin
            failures++; $display("FAIL bypass got rs1=%0d stale=%0d want 40 40", phys_rs1[11:6], phys_stale[11:6]); end
        idle(); lane(0, 1, 4, 4, 0, 0, 0);
        cycle();
        checks++; if (phys_rs1[5:0] !== 6'd41) begin
            failures++; $display("FAIL bypass_highest got %0d want 41", phys_rs1[5:0]); end
    endtask

    task automatic test_ckpt_restore();
        do_reset();
        lane(0, 1, 0, 0, 2, 1, 50); lane(1, 1, 0, 0, 2, 1, 51); ckpt_req = 1; ckpt_lane = 1'b0;
        cycle();
        checks++; if (ckpt_ack !== 1'b1 || ckpt_id !== 3'd0) begin
            failures++; $display("FAIL ckpt_take got ack=%b id=%0d want 1 0", ckpt_ack, ckpt_id); end
        idle(); restore = 1; restore_id = 3'd0;
        cycle();
        checks++; if (out_valid !== 2'b00 || ckpt_ack !== 1'b0 || ckpt_empty !== 1'b0) begin
            failures++; $display("FAIL restore0 got ov=%b ack=%b empty=%b want 00 0 0", out_valid, ckpt_ack, ckpt_empty); end
        idle(); lane(0, 1, 2, 0, 0, 0, 0);
        cycle();
        checks++; if (phys_rs1[5:0] !== 6'd50) begin
            failures++; $display("FAIL restore0_map got %0d want 50", phys_rs1[5:0]); end
        idle(); ckpt_req = 1;
        cycle();
        checks++; if (ckpt_ack !== 1'b1 || ckpt_id !== 3'd1) begin
            failures++; $display("FAIL restore0_tail got ack=%b id=%0d want 1 1", ckpt_ack, ckpt_id); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int k = 0; k < NC; k++) begin
            idle(); ckpt_req = 1;
            cycle();
            checks++; if (ckpt_ack !== 1'b1 || ckpt_id !== CW'(k)) begin
                failures++; $display("FAIL fill_%0d got ack=%b id=%0d want 1 %0d", k, ckpt_ack, ckpt_id, k); end
        end
        checks++; if (ckpt_full !== 1'b1) begin
            failures++; $display("FAIL full_flag got %b want 1", ckpt_full); end
        idle(); ckpt_req = 1; lane(0, 1, 9, 0, 0, 0, 0);
        cycle();
        checks++; if (ckpt_ack !== 1'b0 || out_valid !== 2'b01 || phys_rs1[5:0] !== 6'd9) begin
            failures++; $display("FAIL full_drop got ack=%b ov=%b rs1=%0d want 0 01 9", ckpt_ack, out_valid, phys_rs1[5:0]); end
        idle(); ckpt_release = 1;
        cycle();
        checks++; if (ckpt_full !== 1'b0) begin
            failures++; $display("FAIL release_full got %b want 0", ckpt_full); end
        idle(); ckpt_req = 1;
        cycle();
        checks++; if (ckpt_ack !== 1'b1 || ckpt_id !== 3'd0) begin
            failures++; $display("FAIL wrap got ack=%b id=%0d want 1 0", ckpt_ack, ckpt_id); end
    endtask

    task automatic test_restore_priority();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            idle(); lane(0, 1, 0, 0, 10, 1, 20 + k); ckpt_req = 1;
            cycle();
        end
        idle(); restore = 1; restore_id = 3'd1; ckpt_release = 1; ckpt_req = 1;
        lane(0, 1, 0, 0, 10, 1, 30); lane(1, 1, 0, 0, 11, 1, 31);
        cycle();
        checks++; if (out_valid !== 2'b00 || ckpt_ack !== 1'b0) begin
            failures++; $display("FAIL restore_prio got ov=%b ack=%b want 00 0", out_valid, ckpt_ack); end
        idle(); lane(0, 1, 10, 11, 0, 0, 0);
        cycle();
        checks++; if (phys_rs1[5:0] !== 6'd21 || phys_rs2[5:0] !== 6'd11) begin
            failures++; $display("FAIL restore_map got %0d %0d want 21 11", phys_rs1[5:0], phys_rs2[5:0]); end
        idle(); ckpt_release = 1;
        cycle();
        checks++; if (ckpt_empty !== 1'b0) begin
            failures++; $display("FAIL restore_count1 got empty=%b want 0", ckpt_empty); end
        cycle();
        checks++; if (ckpt_empty !== 1'b1) begin
            failures++; $display("FAIL restore_count2 got empty=%b want 1", ckpt_empty); end
        idle(); restore = 1; restore_id = 3'd1; lane(0, 1, 3, 0, 0, 0, 0);
        cycle();
        checks++; if (out_valid !== 2'b01 || phys_rs1[5:0] !== 6'd3) begin
            failures++; $display("FAIL restore_oob got ov=%b rs1=%0d want 01 3", out_valid, phys_rs1[5:0]); end
    endtask

    task automatic test_x0();
        logic [PW-1:0] want;
`ifdef TBOOM_RMT_X0_HARDWIRE_EN
        want = 6'd0;
`else
        want = 6'd33;
`endif
        do_reset();
        lane(0, 1, 0, 0, 0, 1, 33);
        cycle();
        idle(); lane(0, 1, 0, 0, 0, 0, 0);
        cycle();
        checks++; if (phys_rs1[5:0] !== want) begin
            failures++; $display("FAIL x0 got %0d want %0d", phys_rs1[5:0], want); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            idle();
            rst = ($urandom_range(0, 199) == 0);
            for (int l = 0; l < RW; l++)
                lane(l, $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 63));
            ckpt_req = ($urandom_range(0, 2) == 0);
            ckpt_lane = 1'($urandom_range(0, 1));
            ckpt_release = ($urandom_range(0, 3) == 0);
            restore = ($urandom_range(0, 11) == 0);
            restore_id = CW'($urandom_range(0, 7));
            cycle();
            checks++; if (out_valid !== e_ov || ckpt_ack !== e_ack) begin
                failures++; $display("FAIL rnd_ctrl@%0d got ov=%b ack=%b want %b %b", n, out_valid, ckpt_ack, e_ov, e_ack); end
            if (e_ack) begin
                checks++; if (ckpt_id !== CW'(e_id)) begin
                    failures++; $display("FAIL rnd_id@%0d got %0d want %0d", n, ckpt_id, e_id); end
            end
            checks++; if (ckpt_full !== (m_count == NC) || ckpt_empty !== (m_count == 0)) begin
                failures++; $display("FAIL rnd_flags@%0d got full=%b empty=%b count=%0d", n, ckpt_full, ckpt_empty, m_count); end
            for (int j = 0; j < RW; j++) begin
                if (e_ov[j]) begin
                    checks++; if (phys_rs1[j*PW +: PW] !== PW'(e_rs1[j]) || phys_rs2[j*PW +: PW] !== PW'(e_rs2[j])
                                 || phys_stale[j*PW +: PW] !== PW'(e_st[j])) begin
                        failures++;
                        $display("FAIL rnd_lane%0d@%0d got %0d %0d %0d want %0d %0d %0d", j, n,
                                 phys_rs1[j*PW +: PW], phys_rs2[j*PW +: PW], phys_stale[j*PW +: PW],
                                 e_rs1[j], e_rs2[j], e_st[j]);
                    end
                end
            end
        end
    endtask

    initial begin
        idle();
        @(posedge clk); #1;
        test_reset();
        test_basic_lookup();
        test_bypass();
        test_ckpt_restore();
        test_full_wrap();
        test_restore_priority();
        test_x0();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
